// File: rtl/io_ctrl_pkg.sv
// Shared constants and helpers for the memory-mapped I/O controller.
// Register addresses and bus widths used by io_ctrl_gen and its bench.
package io_ctrl_pkg;

  localparam int IO_DATA_W = 8;
  localparam int IO_ADDR_W = 5;

  typedef logic [IO_ADDR_W-1:0] io_addr_t;
  typedef logic [IO_DATA_W-1:0] io_data_t;

  localparam io_addr_t IO_ADDR_IN       = 5'd0;
  localparam io_addr_t IO_ADDR_LED      = 5'd1;
  localparam io_addr_t IO_ADDR_IRQ_STAT = 5'd2;
  localparam io_addr_t IO_ADDR_IRQ_MASK = 5'd3;
  localparam io_addr_t IO_ADDR_EDGE_SEL = 5'd4;
  localparam io_addr_t IO_ADDR_PWM      = 5'd5;

  function automatic io_data_t low_mask(input int n);
    return io_data_t'((1 << n) - 1);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for one input.
// rise/fall pulse in the cycle whose clock edge updates stable.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic meta_q, sync_q;
  logic stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic flip;

  always_comb begin
    flip     = (sync_q != stable_q) && (cnt_q == LAST);
    stable_d = flip ? sync_q : stable_q;
    cnt_d    = cnt_q + 1'b1;
    if (sync_q == stable_q || flip) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = flip & sync_q;
  assign fall   = flip & ~sync_q;

endmodule

// File: rtl/io_ctrl_gen.sv
// Memory-mapped key/switch/LED controller with sticky edge interrupts.
// Optional LED PWM dimming enabled by defining IO_CTRL_GEN_PWM_EN.
module io_ctrl_gen
  import io_ctrl_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SWITCHES    = 4,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [IO_ADDR_W-1:0]    readaddr,
  output logic [IO_DATA_W-1:0]    readdata,
  input  logic [IO_ADDR_W-1:0]    writeaddr,
  input  logic [IO_DATA_W-1:0]    writedata,
  input  logic                    write_en,
  output logic [7:0]              interrupts,
  input  logic [NUM_KEYS-1:0]     keys,
  input  logic [NUM_SWITCHES-1:0] switches,
  output logic [NUM_LEDS-1:0]     leds
);

  localparam int NUM_IN = NUM_KEYS + NUM_SWITCHES;
  localparam io_data_t IN_MASK  = low_mask(NUM_IN);
  localparam io_data_t LED_MASK = low_mask(NUM_LEDS);

  io_data_t stable, rise, fall;

  for (genvar i = 0; i < IO_DATA_W; i++) begin : g_in
    if (i < NUM_KEYS) begin : g_key
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (keys[i]),
        .stable (stable[i]),
        .rise   (rise[i]),
        .fall   (fall[i])
      );
    end else if (i < NUM_IN) begin : g_sw
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (switches[i-NUM_KEYS]),
        .stable (stable[i]),
        .rise   (rise[i]),
        .fall   (fall[i])
      );
    end else begin : g_pad
      assign stable[i] = 1'b0;
      assign rise[i]   = 1'b0;
      assign fall[i]   = 1'b0;
    end
  end

  io_data_t led_q, led_d;
  io_data_t stat_q, stat_d;
  io_data_t mask_q, mask_d;
  io_data_t esel_q, esel_d;
  io_data_t rd_q, rd_d;
  io_data_t pwm_rd;
  io_data_t clr;
  logic wr_led, wr_stat, wr_mask, wr_esel;

  always_comb begin
    wr_led  = write_en && (writeaddr == IO_ADDR_LED);
    wr_stat = write_en && (writeaddr == IO_ADDR_IRQ_STAT);
    wr_mask = write_en && (writeaddr == IO_ADDR_IRQ_MASK);
    wr_esel = write_en && (writeaddr == IO_ADDR_EDGE_SEL);
    led_d   = wr_led  ? (writedata & LED_MASK) : led_q;
    mask_d  = wr_mask ? (writedata & IN_MASK)  : mask_q;
    esel_d  = wr_esel ? (writedata & IN_MASK)  : esel_q;
    clr     = wr_stat ? writedata : '0;
    // a same-cycle event beats the W1C clear
    stat_d  = ((stat_q & ~clr) | rise | (fall & ~esel_q)) & IN_MASK;
    rd_d    = '0;
    unique case (1'b1)
      readaddr == IO_ADDR_IN:       rd_d = stable;
      readaddr == IO_ADDR_LED:      rd_d = led_q;
      readaddr == IO_ADDR_IRQ_STAT: rd_d = stat_q;
      readaddr == IO_ADDR_IRQ_MASK: rd_d = mask_q;
      readaddr == IO_ADDR_EDGE_SEL: rd_d = esel_q;
      readaddr == IO_ADDR_PWM:      rd_d = pwm_rd;
      default:                      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q  <= '0;
      stat_q <= '0;
      mask_q <= '0;
      esel_q <= '0;
      rd_q   <= '0;
    end else begin
      led_q  <= led_d;
      stat_q <= stat_d;
      mask_q <= mask_d;
      esel_q <= esel_d;
      rd_q   <= rd_d;
    end
  end

`ifdef IO_CTRL_GEN_PWM_EN
  io_data_t duty_q, duty_d;
  io_data_t pcnt_q, pcnt_d;
  logic pwm_on;

  always_comb begin
    duty_d = (write_en && (writeaddr == IO_ADDR_PWM)) ? writedata : duty_q;
    pcnt_d = pcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q <= 8'hFF;
      pcnt_q <= '0;
    end else begin
      duty_q <= duty_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign pwm_on = (duty_q == 8'hFF) | (pcnt_q < duty_q);
  assign pwm_rd = duty_q;
  assign leds   = led_q[NUM_LEDS-1:0] & {NUM_LEDS{pwm_on}};
`else
  assign pwm_rd = '0;
  assign leds   = led_q[NUM_LEDS-1:0];
`endif

  assign readdata   = rd_q;
  assign interrupts = {7'b0, |(stat_q & mask_q)};

endmodule

// File: tb/tb_io_ctrl_gen.sv
// Bench for io_ctrl_gen: directed checks plus randomized traffic
// compared every cycle against a window-based behavioural model.
module tb_io_ctrl_gen;

  localparam int DC = 4;
  localparam int NK = 4;
  localparam int NS = 4;
  localparam int NL = 4;
`ifdef IO_CTRL_GEN_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] readaddr, writeaddr;
  logic [7:0] readdata, writedata, interrupts;
  logic write_en;
  logic [NK-1:0] keys;
  logic [NS-1:0] switches;
  logic [NL-1:0] leds;

  always #5 clk = ~clk;

  io_ctrl_gen #(
    .NUM_KEYS(NK), .NUM_SWITCHES(NS),
    .NUM_LEDS(NL), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset_n(rst_n),
    .readaddr(readaddr), .readdata(readdata),
    .writeaddr(writeaddr), .writedata(writedata),
    .write_en(write_en), .interrupts(interrupts),
    .keys(keys), .switches(switches), .leds(leds)
  );

  int vecs = 0;
  int errs = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a bit's accepted level flips once the last DC synchronised
  // samples all disagree with it; sync lags the pin by two clocks.
  logic [7:0] m_p1, m_p2, m_st, m_led, m_stat, m_mask, m_esel;
  logic [7:0] m_rd, m_duty, m_pcnt;
  logic [7:0] m_win [DC];

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] flip, ev, clr;
    if (!rst_n) begin
      m_p1 = 0; m_p2 = 0; m_st = 0; m_led = 0; m_stat = 0;
      m_mask = 0; m_esel = 0; m_rd = 0; m_pcnt = 0;
      m_duty = 8'hFF;
      for (int k = 0; k < DC; k++) m_win[k] = 0;
    end else begin
      for (int k = DC - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_p2;
      flip = 8'hFF;
      for (int k = 0; k < DC; k++) flip &= m_win[k] ^ m_st;
      ev = (flip & ~m_st) | (flip & m_st & ~m_esel);
      clr = (write_en && writeaddr == 5'd2) ? writedata : 8'h00;
      case (readaddr)
        5'd0: m_rd = m_st;
        5'd1: m_rd = m_led;
        5'd2: m_rd = m_stat;
        5'd3: m_rd = m_mask;
        5'd4: m_rd = m_esel;
        5'd5: m_rd = PWM ? m_duty : 8'h00;
        default: m_rd = 8'h00;
      endcase
      m_stat = (m_stat & ~clr) | ev;
      if (write_en) begin
        case (writeaddr)
          5'd1: m_led = writedata & 8'h0F;
          5'd3: m_mask = writedata;
          5'd4: m_esel = writedata;
          5'd5: if (PWM) m_duty = writedata;
          default: ;
        endcase
      end
      m_st = m_st ^ flip;
      m_pcnt = m_pcnt + 8'd1;
      m_p2 = m_p1;
      m_p1 = {switches, keys};
    end
  end

  function automatic logic [NL-1:0] m_leds();
    logic on;
    on = (m_duty == 8'hFF) || (m_pcnt < m_duty);
    return m_led[NL-1:0] & {NL{on}};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("readdata", readdata, m_rd);
      chk("leds", leds, m_leds());
      chk("interrupts", interrupts, {7'b0, |(m_stat & m_mask)});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    writeaddr = a; writedata = d; write_en = 1'b1;
    cyc();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    readaddr = a;
    cyc();
    d = readdata;
  endtask

  logic [7:0] r;
  logic [7:0] seen [1:8];
  int hi;

  initial begin
    rst_n = 1'b0; readaddr = 0; writeaddr = 0; writedata = 0;
    write_en = 0; keys = 0; switches = 0;
    cyc(3);
    chk("rst_readdata", readdata, 8'h00);
    chk("rst_leds", leds, 4'h0);
    chk("rst_irq", interrupts, 8'h00);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    wr(5'd1, 8'hFF);
    chk("led_drive", leds, 4'hF);
    rd(5'd1, r); chk("led_readback", r, 8'h0F);
    rd(5'd7, r); chk("addr7", r, 8'h00);
    readaddr = 5'd1;
    #1 chk("rd_latency_old", readdata, 8'h00);
    cyc(); chk("rd_latency_new", readdata, 8'h0F);

    readaddr = 5'd0;
    keys = 4'h1; cyc(3); keys = 4'h0; cyc(8);
    chk("glitch_ignored", readdata, 8'h00);
    keys = 4'h1;
    for (int c = 1; c <= 8; c++) begin
      cyc(); seen[c] = readdata;
    end
    chk("in_before_accept", seen[6], 8'h00);
    chk("in_after_accept", seen[7], 8'h01);
    rd(5'd2, r); chk("stat_rise", r, 8'h01);

    wr(5'd2, 8'h01);
    wr(5'd3, 8'h01);
    keys = 4'h0; cyc(10);
    chk("irq_fall", interrupts, 8'h01);
    rd(5'd2, r); chk("stat_fall", r, 8'h01);
    wr(5'd2, 8'h01);
    chk("irq_w1c", interrupts, 8'h00);

    wr(5'd4, 8'h01);
    keys = 4'h1; cyc(10);
    wr(5'd2, 8'h01);
    keys = 4'h0; cyc(10);
    rd(5'd2, r); chk("fall_ignored", r, 8'h00);
    chk("fall_no_irq", interrupts, 8'h00);
    keys = 4'h1; cyc(5);
    wr(5'd2, 8'h01);
    rd(5'd2, r); chk("event_beats_w1c", r, 8'h01);
    chk("event_irq", interrupts, 8'h01);

    wr(5'd1, 8'h05);
    keys = 4'h0;
    cmp_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrst_leds", leds, 4'h0);
    chk("midrst_irq", interrupts, 8'h00);
    cyc(2);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(5'(a), r);
      chk("post_rst_reg", r, (PWM && a == 5) ? 8'hFF : 8'h00);
    end

    if (PWM) begin
      wr(5'd1, 8'h01);
      hi = 0;
      for (int c = 0; c < 256; c++) begin cyc(); hi += int'(leds[0]); end
      chk("pwm_ff", hi, 256);
      wr(5'd5, 8'd64);
      hi = 0;
      for (int c = 0; c < 256; c++) begin cyc(); hi += int'(leds[0]); end
      chk("pwm_64", hi, 64);
      wr(5'd5, 8'd0);
      hi = 0;
      for (int c = 0; c < 256; c++) begin cyc(); hi += int'(leds[0]); end
      chk("pwm_0", hi, 0);
    end

    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (c == 2000) begin
        cmp_en = 1'b0;
        #2 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cmp_en = 1'b1;
      end
      for (int b = 0; b < NK; b++)
        if ($urandom_range(0, 15) == 0) keys[b] = ~keys[b];
      for (int b = 0; b < NS; b++)
        if ($urandom_range(0, 15) == 0) switches[b] = ~switches[b];
      readaddr  = 5'($urandom_range(0, 7));
      writeaddr = 5'($urandom_range(0, 7));
      writedata = 8'($urandom);
      write_en  = ($urandom_range(0, 3) == 0);
    end
    write_en = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
